// File: rtl/differentiator.sv
// Scaled first-difference stage: y[n] = sat(((x[n] - x[n-1]) * freq_in) >>> GAIN_SHIFT).
// Three register stages after the sample capture, with bypass and clear while disabled.
module differentiator #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int BITDEPTH      = 16,
   parameter int REG_DATAWIDTH = 16,
   parameter int GAIN_SHIFT    = 8
) (
   input  logic                       clk_in,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [REG_DATAWIDTH-1:0]   freq_in,
   input  logic signed [BITDEPTH-1:0] sig_in,
   output logic signed [BITDEPTH-1:0] sig_out,
   output logic                       sat_out
);

   localparam int B      = BITDEPTH;
   localparam int R      = REG_DATAWIDTH;
   localparam int P      = B + R + 2;
   localparam int STAGES = 3;

   // A non-positive clock frequency is a misconfiguration; the stage then stays in bypass.
   localparam logic CLK_OK = (CLK_FREQ > 0);

   localparam logic signed [P-1:0] S_MAX = {{(P-B+1){1'b0}}, {(B-1){1'b1}}};
   localparam logic signed [P-1:0] S_MIN = {{(P-B+1){1'b1}}, {(B-1){1'b0}}};

   logic                  run;
   logic signed [B-1:0]   x_prev;
   logic signed [B:0]     d1;
   logic signed [R:0]     gain;
   logic signed [P-1:0]   p2;
   logic signed [P-1:0]   s;
   logic signed [B-1:0]   s_clamp;
   logic                  clip;
   logic signed [B-1:0]   out_reg;
   logic                  sat_reg;
   // [0] = previous sample held, [1..3] = stage 1..3 valid
   logic [STAGES:0]       vld_pipe;

   assign run  = enable & CLK_OK;
   assign gain = {1'b0, freq_in};

   always_comb begin
      s       = p2 >>> GAIN_SHIFT;
      s_clamp = s[B-1:0];
      clip    = 1'b0;
      if (s > S_MAX) begin
         s_clamp = {1'b0, {(B-1){1'b1}}};
         clip    = 1'b1;
      end else if (s < S_MIN) begin
         s_clamp = {1'b1, {(B-1){1'b0}}};
         clip    = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         x_prev   <= '0;
         d1       <= '0;
         p2       <= '0;
         out_reg  <= '0;
         sat_reg  <= 1'b0;
         vld_pipe <= '0;
      end else if (!run) begin
         x_prev   <= '0;
         d1       <= '0;
         p2       <= '0;
         out_reg  <= '0;
         sat_reg  <= 1'b0;
         vld_pipe <= '0;
      end else begin
         x_prev   <= sig_in;
         vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
         // B+1 bits holds any difference of two B-bit samples exactly
         d1       <= vld_pipe[0] ? ({sig_in[B-1], sig_in} - {x_prev[B-1], x_prev}) : '0;
         p2       <= P'(d1) * P'(gain);
         out_reg  <= s_clamp;
         sat_reg  <= clip;
      end
   end

   assign sig_out = run ? (vld_pipe[STAGES] ? out_reg : '0) : sig_in;
   assign sat_out = run & vld_pipe[STAGES] & sat_reg;

endmodule

// File: tb/tb_differentiator.sv
// Randomized and directed bench for differentiator, checked every cycle against
// a sample-history model of the scaled, floored, saturated first difference.
module tb_differentiator;

   localparam int SH = 8;

   logic               clk_in  = 1'b0;
   logic               reset_n = 1'b0;
   logic               enable  = 1'b0;
   logic [15:0]        freq_in = '0;
   logic signed [15:0] sig_in  = '0;
   logic signed [15:0] sig_out;
   logic               sat_out;

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   differentiator #(.GAIN_SHIFT(SH)) dut (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .enable (enable),
      .freq_in(freq_in),
      .sig_in (sig_in),
      .sig_out(sig_out),
      .sat_out(sat_out)
   );

   task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   // Model: consecutive enabled edges since the last reset/disable, plus sample history.
   int     cnt = 0;
   longint hx[4];
   longint hf[4];

   always @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) cnt <= 0;
      else begin
         for (int i = 3; i > 0; i--) begin
            hx[i] <= hx[i-1];
            hf[i] <= hf[i-1];
         end
         hx[0] <= longint'(sig_in);
         hf[0] <= longint'(freq_in);
         if (!enable)       cnt <= 0;
         else if (cnt < 100) cnt <= cnt + 1;
      end
   end

   // After edge k the output is the difference x[k-2]-x[k-3] scaled by freq at edge k-1.
   task automatic model_y(output logic signed [31:0] y, output logic s);
      longint d, p, q, dv;
      dv = longint'(1) << SH;
      d  = hx[2] - hx[3];
      p  = d * hf[1];
      if (p >= 0) q = p / dv;
      else        q = -((-p + dv - 1) / dv);
      if (q > 32767)       begin y = 32767;  s = 1'b1; end
      else if (q < -32768) begin y = -32768; s = 1'b1; end
      else                 begin y = 32'(q); s = 1'b0; end
   endtask

   initial begin
      logic signed [31:0] y;
      logic               s;
      forever begin
         @(negedge clk_in);
         model_y(y, s);
         if (enable) begin
            chk("stream_out", sig_out, (cnt >= 4) ? y : 0);
            chk("stream_sat", sat_out, (cnt >= 4 && s) ? 1 : 0);
         end else begin
            chk("stream_bypass", sig_out, sig_in);
            chk("stream_bypass_sat", sat_out, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic step(input logic signed [15:0] x, input logic [15:0] f, input logic en);
      sig_in  = x;
      freq_in = f;
      enable  = en;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle2();
      step(16'sd0, 16'd0, 1'b0);
      step(16'sd0, 16'd0, 1'b0);
   endtask

   initial begin
      logic signed [15:0] xr;
      logic [15:0]        fr;
      logic               er;
      int                 xi;

      // reset and bypass
      sig_in = 16'sd1234;
      #2;
      chk("bypass_1234", sig_out, 1234);
      chk("bypass_sat", sat_out, 0);
      enable = 1'b1;
      #1;
      chk("reset_en_out", sig_out, 0);
      chk("reset_en_sat", sat_out, 0);
      @(posedge clk_in);
      #1;
      reset_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step(16'(n * 300), 16'd256, 1'b1);
         chk("post_reset", sig_out, (n >= 3) ? 300 : 0);
      end
      idle2();

      // ramp
      for (int n = 0; n < 12; n++) begin
         step(16'(n * 10), 16'd256, 1'b1);
         chk("ramp", sig_out, (n >= 3) ? 10 : 0);
      end
      idle2();

      // step
      for (int n = 0; n < 10; n++) begin
         step((n < 4) ? 16'sd0 : 16'sd1000, 16'd512, 1'b1);
         chk("step", sig_out, (n == 6) ? 2000 : 0);
      end
      idle2();

      // saturation at unit gain, then no saturation at gain 1
      for (int n = 0; n < 10; n++) begin
         step((n % 2 == 0) ? -16'sd32768 : 16'sd32767, 16'd256, 1'b1);
         if (n >= 3) begin
            chk("sat_val", sig_out, (n % 2 == 1) ? 32767 : -32768);
            chk("sat_flag", sat_out, 1);
         end
      end
      idle2();
      for (int n = 0; n < 10; n++) begin
         step((n % 2 == 0) ? -16'sd32768 : 16'sd32767, 16'd1, 1'b1);
         if (n >= 3) begin
            chk("nosat_val", sig_out, (n % 2 == 1) ? 255 : -256);
            chk("nosat_flag", sat_out, 0);
         end
      end
      idle2();

      // floor rounding
      for (int n = 0; n < 9; n++) begin
         step((n == 2 || n == 3) ? -16'sd1 : 16'sd0, 16'd1, 1'b1);
         chk("floor", sig_out, (n == 4) ? -1 : 0);
      end
      for (int n = 0; n < 8; n++) begin
         step(16'($urandom), 16'd0, 1'b1);
         if (n >= 3) chk("freq0", sig_out, 0);
      end
      idle2();

      // one-cycle enable drop while running
      for (int n = 0; n < 6; n++) step(16'(n * 7), 16'd256, 1'b1);
      sig_in = 16'sd777;
      enable = 1'b0;
      #1;
      chk("drop_bypass", sig_out, 777);
      @(posedge clk_in);
      #1;
      for (int n = 0; n < 5; n++) begin
         step(16'(1000 + n * 5), 16'd256, 1'b1);
         chk("reprime", sig_out, (n >= 3) ? 5 : 0);
      end

      // async reset pulse between edges
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out", sig_out, 0);
      chk("async_rst_sat", sat_out, 0);
      @(negedge clk_in);
      #1;
      reset_n = 1'b1;

      // randomized traffic
      xr = '0;
      for (int i = 0; i < 3000; i++) begin
         er = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 2) == 0) xr = 16'($urandom);
         else begin
            xi = int'(xr) + int'($urandom_range(0, 400)) - 200;
            xr = 16'(xi);
         end
         case ($urandom_range(0, 4))
            0:       fr = 16'd0;
            1:       fr = 16'd1;
            2:       fr = 16'd256;
            default: fr = 16'($urandom);
         endcase
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            #1;
            reset_n = 1'b1;
         end
         step(xr, fr, er);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
